// File: rtl/bit_clk_pkg.sv
// Shared constants and state type for the bit-clock link (transmitter and recovery).
package bit_clk_pkg;

    localparam int DEF_CLK_LEN = 16;
    localparam int MIN_PERIOD  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2
    } tx_state_t;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: counts 0..period-1 while running, restartable on frame load.
// Latency: flags are combinational from the registered count; no backpressure.
module bit_timer
    import bit_clk_pkg::*;
#(
    parameter int CLK_LEN = DEF_CLK_LEN
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               restart_i,
    input  logic               run_i,
    input  logic [CLK_LEN-1:0] period_i,
    output logic               first_o,
    output logic               last_o
);

    logic [CLK_LEN-1:0] cnt_q;

    assign first_o = (cnt_q == '0);
    assign last_o  = (cnt_q == period_i - 1'b1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (restart_i) begin
            cnt_q <= '0;
        end else if (run_i) begin
            // period is clamped to >= 2 upstream, so the wrap never overflows
            cnt_q <= last_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/bit_stream_tx.sv
// NRZ serializer, MSB first, programmable bit period; optional preamble via PREAMBLE_EN.
// Latency: first bit on signal_out one cycle after accept. Backpressure: data_ready only in IDLE or last cycle of last bit.
module bit_stream_tx
    import bit_clk_pkg::*;
#(
    parameter int CLK_LEN = DEF_CLK_LEN,
    parameter int DATA_W  = 8
`ifdef PREAMBLE_EN
    ,
    parameter int PRE_LEN = 8
`endif
) (
    input  logic               clk_300M,
    input  logic               rst_n,
    input  logic [CLK_LEN-1:0] bit_period,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               data_valid,
    output logic               data_ready,
    output logic               signal_out,
    output logic               bit_strobe,
    output logic               busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    tx_state_t          state_q;
    logic [DATA_W-1:0]  sh_q;
    logic               line_q;
    logic [CLK_LEN-1:0] period_l_q;
    logic [CLK_LEN-1:0] period_l_d;
    logic [IDX_W-1:0]   bit_idx_q;
    logic               ready_en_q;
    logic               tmr_first;
    logic               tmr_last;
    logic               last_data_bit;
    logic               accept;

`ifdef PREAMBLE_EN
    localparam int PRE_W = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
    logic [PRE_W-1:0]   pre_idx_q;
`endif

    assign period_l_d    = (bit_period < CLK_LEN'(MIN_PERIOD)) ? CLK_LEN'(MIN_PERIOD) : bit_period;
    assign last_data_bit = (state_q == DATA) && tmr_last && (bit_idx_q == IDX_W'(DATA_W - 1));
    // ready_en_q keeps data_ready low through reset and the first edge after release
    assign data_ready    = ready_en_q && ((state_q == IDLE) || last_data_bit);
    assign accept        = data_valid && data_ready;
    assign busy          = (state_q != IDLE);
    assign bit_strobe    = busy && tmr_first;
    assign signal_out    = line_q;

    bit_timer #(
        .CLK_LEN (CLK_LEN)
    ) u_timer (
        .clk_i     (clk_300M),
        .rst_ni    (rst_n),
        .restart_i (accept),
        .run_i     (busy),
        .period_i  (period_l_q),
        .first_o   (tmr_first),
        .last_o    (tmr_last)
    );

    always_ff @(posedge clk_300M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            line_q     <= 1'b0;
            period_l_q <= CLK_LEN'(MIN_PERIOD);
            bit_idx_q  <= '0;
            ready_en_q <= 1'b0;
`ifdef PREAMBLE_EN
            pre_idx_q  <= '0;
`endif
        end else begin
            ready_en_q <= 1'b1;
            if (accept) begin
                period_l_q <= period_l_d;
                bit_idx_q  <= '0;
`ifdef PREAMBLE_EN
                state_q    <= PRE;
                sh_q       <= data_in;
                line_q     <= 1'b1;
                pre_idx_q  <= '0;
`else
                state_q    <= DATA;
                sh_q       <= {data_in[DATA_W-2:0], 1'b0};
                line_q     <= data_in[DATA_W-1];
`endif
            end else if (busy && tmr_last) begin
                case (state_q)
`ifdef PREAMBLE_EN
                    PRE: begin
                        if (pre_idx_q == PRE_W'(PRE_LEN - 1)) begin
                            state_q <= DATA;
                            line_q  <= sh_q[DATA_W-1];
                            sh_q    <= {sh_q[DATA_W-2:0], 1'b0};
                        end else begin
                            line_q    <= ~line_q;
                            pre_idx_q <= pre_idx_q + 1'b1;
                        end
                    end
`endif
                    DATA: begin
                        // at frame end the line keeps its last level in IDLE
                        if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                            state_q <= IDLE;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            line_q    <= sh_q[DATA_W-1];
                            sh_q      <= {sh_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bit_stream_tx.sv
// Self-checking bench for bit_stream_tx: per-cycle comparison against a frame-level model.
module tb_bit_stream_tx;

`ifdef PREAMBLE_EN
    localparam int PRE_BITS = 8;
`else
    localparam int PRE_BITS = 0;
`endif

    logic        clk_300M = 1'b0;
    logic        rst_n;
    logic [15:0] bit_period;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic        signal_out;
    logic        bit_strobe;
    logic        busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [7:0] fr_dat[8];
    int         fr_per[8];
    int         fr_mid[8];
    int         n_fr;

    always #5 clk_300M = ~clk_300M;

    bit_stream_tx dut (
        .clk_300M   (clk_300M),
        .rst_n      (rst_n),
        .bit_period (bit_period),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .signal_out (signal_out),
        .bit_strobe (bit_strobe),
        .busy       (busy)
    );

    // Offers fr_dat[0..n_fr-1] with valid held high, checking every cycle against
    // the expected waveform: each frame is (preamble +) 8 bits of max(period,2) cycles.
    task automatic run_frames();
        int   p;
        int   nbits;
        logic exp_line;
        logic exp_ready;
        logic last_line;
        last_line = 1'b0;
        @(negedge clk_300M);
        chk_cnt++;
        if (data_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", data_ready);
        else pass_cnt++;
        data_in    = fr_dat[0];
        bit_period = 16'(fr_per[0]);
        data_valid = 1'b1;
        for (int f = 0; f < n_fr; f++) begin
            p     = (fr_per[f] < 2) ? 2 : fr_per[f];
            nbits = PRE_BITS + 8;
            for (int b = 0; b < nbits; b++) begin
                for (int c = 0; c < p; c++) begin
                    @(negedge clk_300M);
                    exp_line  = (b < PRE_BITS) ? ((b % 2) == 0) : fr_dat[f][7 - (b - PRE_BITS)];
                    exp_ready = (b == nbits - 1) && (c == p - 1);
                    chk_cnt++;
                    if (signal_out !== exp_line)
                        $display("FAIL line f%0d b%0d c%0d: got %b want %b", f, b, c, signal_out, exp_line);
                    else pass_cnt++;
                    chk_cnt++;
                    if (bit_strobe !== (c == 0))
                        $display("FAIL strobe f%0d b%0d c%0d: got %b want %b", f, b, c, bit_strobe, (c == 0));
                    else pass_cnt++;
                    chk_cnt++;
                    if (busy !== 1'b1)
                        $display("FAIL busy f%0d b%0d c%0d: got %b want 1", f, b, c, busy);
                    else pass_cnt++;
                    chk_cnt++;
                    if (data_ready !== exp_ready)
                        $display("FAIL ready f%0d b%0d c%0d: got %b want %b", f, b, c, data_ready, exp_ready);
                    else pass_cnt++;
                    if (b == 1 && c == 0) begin
                        bit_period = 16'(fr_mid[f]);
                        data_in    = 8'($urandom);
                    end
                    if (exp_ready) begin
                        if (f < n_fr - 1) begin
                            data_in    = fr_dat[f + 1];
                            bit_period = 16'(fr_per[f + 1]);
                        end else begin
                            data_valid = 1'b0;
                        end
                    end
                    last_line = exp_line;
                end
            end
        end
        @(negedge clk_300M);
        chk_cnt++;
        if (busy !== 1'b0 || bit_strobe !== 1'b0)
            $display("FAIL end_idle: got busy=%b strobe=%b want 0 0", busy, bit_strobe);
        else pass_cnt++;
        chk_cnt++;
        if (signal_out !== last_line)
            $display("FAIL end_hold: got %b want %b", signal_out, last_line);
        else pass_cnt++;
        chk_cnt++;
        if (data_ready !== 1'b1)
            $display("FAIL end_ready: got %b want 1", data_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bit_period = 16'd4;
        data_in    = 8'h00;
        data_valid = 1'b0;
        repeat (3) @(negedge clk_300M);
        chk_cnt++;
        if ({signal_out, bit_strobe, busy, data_ready} !== 4'b0000)
            $display("FAIL reset_outs: got %b want 0000", {signal_out, bit_strobe, busy, data_ready});
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        chk_cnt++;
        if (data_ready !== 1'b0) $display("FAIL ready_before_clk: got %b want 0", data_ready);
        else pass_cnt++;
        @(posedge clk_300M);
        #1;
        chk_cnt++;
        if ({data_ready, busy, signal_out} !== 3'b100)
            $display("FAIL ready_after_clk: got %b want 100", {data_ready, busy, signal_out});
        else pass_cnt++;
    endtask

    task automatic test_basic();
        n_fr = 1; fr_dat[0] = 8'hA5; fr_per[0] = 4; fr_mid[0] = 4;
        run_frames();
    endtask

    task automatic test_min_period();
        n_fr = 1; fr_dat[0] = 8'hF0; fr_per[0] = 1; fr_mid[0] = 7;
        run_frames();
        fr_per[0] = 0; fr_mid[0] = 1;
        run_frames();
    endtask

    task automatic test_back_to_back();
        n_fr = 2;
        fr_dat[0] = 8'h81; fr_per[0] = 3; fr_mid[0] = 3;
        fr_dat[1] = 8'h7E; fr_per[1] = 3; fr_mid[1] = 3;
        run_frames();
    endtask

    task automatic test_period_change();
        n_fr = 2;
        fr_dat[0] = 8'($urandom); fr_per[0] = 5; fr_mid[0] = 9;
        fr_dat[1] = 8'($urandom); fr_per[1] = 9; fr_mid[1] = 2;
        run_frames();
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk_300M);
        data_in    = 8'hFF;
        bit_period = 16'd4;
        data_valid = 1'b1;
        @(negedge clk_300M);
        data_valid = 1'b0;
        repeat (12) @(negedge clk_300M);
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_before_abort: got %b want 1", busy);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({signal_out, busy, bit_strobe, data_ready} !== 4'b0000)
            $display("FAIL async_abort: got %b want 0000", {signal_out, busy, bit_strobe, data_ready});
        else pass_cnt++;
        @(negedge clk_300M);
        rst_n = 1'b1;
        @(posedge clk_300M);
        n_fr = 1; fr_dat[0] = 8'($urandom); fr_per[0] = int'($urandom_range(0, 5)); fr_mid[0] = 3;
        run_frames();
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            n_fr = int'($urandom_range(1, 3));
            for (int f = 0; f < n_fr; f++) begin
                fr_dat[f] = 8'($urandom);
                fr_per[f] = int'($urandom_range(0, 6));
                fr_mid[f] = int'($urandom_range(0, 12));
            end
            run_frames();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_period();
        test_back_to_back();
        test_period_change();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
